// File: rtl/note_sequencer_pkg.sv
// Shared types, field widths and the equal-tempered note table for the tone sequencer.
package note_sequencer_pkg;

    localparam int unsigned NOTE_W     = 6;
    localparam int unsigned DUR_W      = 4;
    localparam int unsigned ENTRY_W    = NOTE_W + DUR_W;
    localparam int unsigned PERIOD_W   = 21;
    localparam int unsigned UNIT_W     = 5;
    localparam int unsigned NOTE_COUNT = 48;

    localparam logic [NOTE_W-1:0] END_CODE  = 6'h3F;
    localparam logic [NOTE_W-1:0] REST_CODE = 6'h00;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_PLAY,
        S_GAP,
        S_DONE
    } seq_state_t;

    typedef logic [63:0][PERIOD_W-1:0] period_tab_t;

    // Codes 1..48 = C3..B6, frequencies in mHz (A4 = 440 Hz).
    function automatic longint unsigned note_mhz(input int code);
        case (code)
            1:  return 130813;   2:  return 138591;   3:  return 146832;   4:  return 155563;
            5:  return 164814;   6:  return 174614;   7:  return 184997;   8:  return 195998;
            9:  return 207652;   10: return 220000;   11: return 233082;   12: return 246942;
            13: return 261626;   14: return 277183;   15: return 293665;   16: return 311127;
            17: return 329628;   18: return 349228;   19: return 369994;   20: return 391995;
            21: return 415305;   22: return 440000;   23: return 466164;   24: return 493883;
            25: return 523251;   26: return 554365;   27: return 587330;   28: return 622254;
            29: return 659255;   30: return 698456;   31: return 739989;   32: return 783991;
            33: return 830609;   34: return 880000;   35: return 932328;   36: return 987767;
            37: return 1046502;  38: return 1108731;  39: return 1174659;  40: return 1244508;
            41: return 1318510;  42: return 1396913;  43: return 1479978;  44: return 1567982;
            45: return 1661219;  46: return 1760000;  47: return 1864655;  48: return 1975533;
            default: return 0;
        endcase
    endfunction

    // Elaboration-time table: period = round(clk_freq / f); everything outside 1..48 is silent.
    function automatic period_tab_t build_period_tab(input longint unsigned clk_freq);
        period_tab_t       tab;
        longint unsigned   f;
        longint unsigned   p;
        tab = '0;
        for (int i = 0; i < 64; i++) begin
            f = note_mhz(i);
            if (i != int'(REST_CODE) && i <= int'(NOTE_COUNT) && f != 0) begin
                p = (clk_freq * 64'd1000 + f / 64'd2) / f;
                tab[i[5:0]] = PERIOD_W'(p);
            end
        end
        return tab;
    endfunction

endpackage

// File: rtl/note_period_lut.sv
// Constant ROM mapping a note code to its PWM period in clock cycles.
module note_period_lut
    import note_sequencer_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 12_000_000
) (
    input  logic [NOTE_W-1:0]   code,
    output logic [PERIOD_W-1:0] period
);

    localparam period_tab_t PERIOD_TAB = build_period_tab(64'(CLK_FREQ));

    assign period = PERIOD_TAB[code];

endmodule

// File: rtl/note_sequencer.sv
// Song sequencer: walks the song ROM, drives the PWM period/duty and times each note and gap.
//  state    | meaning
//  S_IDLE   | stopped, outputs silent, waits for start
//  S_FETCH  | ROM read issued at idx
//  S_DECODE | ROM word valid; end marker or load new note
//  S_PLAY   | note sounding for (dur+1) units
//  S_GAP    | articulation silence, period held, duty 0
//  S_DONE   | song finished, waits for start
module note_sequencer
    import note_sequencer_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 12_000_000,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned TICK_DIV  = 750_000,
    parameter int unsigned GAP_TICKS = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic                loop_en,
    output logic [ADDR_W-1:0]   rom_addr,
    output logic                rom_en,
    input  logic [ENTRY_W-1:0]  rom_data,
    output logic [PERIOD_W-1:0] period,
    output logic [PERIOD_W-1:0] duty_cycle,
    output logic                note_strobe,
    output logic                busy,
    output logic                done
);

    localparam int unsigned        TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0]  TICK_LOAD = TICK_W'(TICK_DIV - 1);
    localparam logic [UNIT_W-1:0]  GAP_LOAD  = UNIT_W'(GAP_TICKS - 1);

    seq_state_t          state;
    logic [ADDR_W-1:0]   idx;
    logic [TICK_W-1:0]   tick_cnt;
    logic [UNIT_W-1:0]   unit_cnt;
    logic [PERIOD_W-1:0] lut_period;
    logic [NOTE_W-1:0]   code;
    logic [DUR_W-1:0]    dur;
    logic                time_up;
    logic                last_idx;

    assign code     = rom_data[ENTRY_W-1 -: NOTE_W];
    assign dur      = rom_data[DUR_W-1:0];
    assign time_up  = (tick_cnt == '0) && (unit_cnt == '0);
    assign last_idx = &idx;
    assign rom_addr = idx;

    note_period_lut #(.CLK_FREQ(CLK_FREQ)) u_lut (
        .code   (code),
        .period (lut_period)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            idx         <= '0;
            tick_cnt    <= '0;
            unit_cnt    <= '0;
            rom_en      <= 1'b0;
            period      <= '0;
            duty_cycle  <= '0;
            note_strobe <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            note_strobe <= 1'b0;
            done        <= 1'b0;
            if (stop) begin
                state      <= S_IDLE;
                rom_en     <= 1'b0;
                period     <= '0;
                duty_cycle <= '0;
                busy       <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            state  <= S_FETCH;
                            idx    <= '0;
                            rom_en <= 1'b1;
                            busy   <= 1'b1;
                        end
                    end
                    S_FETCH: begin
                        rom_en <= 1'b0;
                        state  <= S_DECODE;
                    end
                    S_DECODE: begin
                        if (code == END_CODE) begin
                            if (loop_en) begin
                                state  <= S_FETCH;
                                idx    <= '0;
                                rom_en <= 1'b1;
                            end else begin
                                state      <= S_DONE;
                                period     <= '0;
                                duty_cycle <= '0;
                                busy       <= 1'b0;
                                done       <= 1'b1;
                            end
                        end else begin
                            state       <= S_PLAY;
                            period      <= lut_period;
                            duty_cycle  <= lut_period >> 1;
                            note_strobe <= 1'b1;
                            tick_cnt    <= TICK_LOAD;
                            unit_cnt    <= {1'b0, dur};
                        end
                    end
                    S_PLAY, S_GAP: begin
                        if (!time_up) begin
                            if (tick_cnt == '0) begin
                                tick_cnt <= TICK_LOAD;
                                unit_cnt <= unit_cnt - 1'b1;
                            end else begin
                                tick_cnt <= tick_cnt - 1'b1;
                            end
                        end else if (state == S_PLAY && GAP_TICKS > 0) begin
                            state      <= S_GAP;
                            duty_cycle <= '0;
                            tick_cnt   <= TICK_LOAD;
                            unit_cnt   <= GAP_LOAD;
                        end else if (last_idx && !loop_en) begin
                            // Last ROM slot finished without an end marker: treat as end of song.
                            state      <= S_DONE;
                            period     <= '0;
                            duty_cycle <= '0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                        end else begin
                            state  <= S_FETCH;
                            idx    <= last_idx ? '0 : idx + 1'b1;
                            rom_en <= 1'b1;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with a small behavioural synchronous song ROM.
module tb_note_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        loop_en = 1'b0;
    logic [3:0]  rom_addr;
    logic        rom_en;
    logic [9:0]  rom_data;
    logic [20:0] period;
    logic [20:0] duty_cycle;
    logic        note_strobe;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    logic [9:0] rom [16];
    logic [9:0] rom_q = '0;

    always #5 clk = ~clk;

    always @(posedge clk) if (rom_en) rom_q <= rom[rom_addr];
    assign rom_data = rom_q;

    note_sequencer #(
        .CLK_FREQ  (12_000_000),
        .ADDR_W    (4),
        .TICK_DIV  (4),
        .GAP_TICKS (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .loop_en     (loop_en),
        .rom_addr    (rom_addr),
        .rom_en      (rom_en),
        .rom_data    (rom_data),
        .period      (period),
        .duty_cycle  (duty_cycle),
        .note_strobe (note_strobe),
        .busy        (busy),
        .done        (done)
    );

    function automatic logic [9:0] ent(input logic [5:0] c, input logic [3:0] d);
        return {c, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = ent(6'h3F, 4'd0);
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({period, duty_cycle, rom_addr, rom_en, note_strobe, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs period=%0d duty=%0d addr=%0d en=%0b strobe=%0b busy=%0b done=%0b exp all 0",
                     period, duty_cycle, rom_addr, rom_en, note_strobe, busy, done);
        end
        tick(); tick();
        reset = 1'b1;
        tick(); tick();
        checks++;
        if (busy !== 1'b0 || rom_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle busy=%0b en=%0b exp 0/0", busy, rom_en);
        end
    endtask

    task automatic test_single_note();
        clear_rom();
        rom[0] = ent(6'd22, 4'd1);
        loop_en = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || rom_en !== 1'b1 || rom_addr !== 4'd0) begin
            errors++;
            $display("FAIL t1_fetch busy=%0b en=%0b addr=%0d exp 1/1/0", busy, rom_en, rom_addr);
        end
        tick(); tick();
        checks++;
        if (period !== 21'd27273 || duty_cycle !== 21'd13636 || note_strobe !== 1'b1) begin
            errors++;
            $display("FAIL t1_note period=%0d duty=%0d strobe=%0b exp 27273/13636/1", period, duty_cycle, note_strobe);
        end
        for (int i = 1; i < 8; i++) begin
            tick();
            checks++;
            if (period !== 21'd27273 || duty_cycle !== 21'd13636 || note_strobe !== 1'b0) begin
                errors++;
                $display("FAIL t1_hold[%0d] period=%0d duty=%0d strobe=%0b exp 27273/13636/0", i, period, duty_cycle, note_strobe);
            end
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (period !== 21'd27273 || duty_cycle !== 21'd0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL t1_gap[%0d] period=%0d duty=%0d busy=%0b exp 27273/0/1", i, period, duty_cycle, busy);
            end
        end
        tick();
        checks++;
        if (rom_en !== 1'b1 || rom_addr !== 4'd1 || period !== 21'd27273 || duty_cycle !== 21'd0) begin
            errors++;
            $display("FAIL t1_next_fetch en=%0b addr=%0d period=%0d duty=%0d exp 1/1/27273/0", rom_en, rom_addr, period, duty_cycle);
        end
        tick(); tick();
        checks++;
        if (done !== 1'b1 || period !== 21'd0 || duty_cycle !== 21'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL t1_done done=%0b period=%0d duty=%0d busy=%0b exp 1/0/0/0", done, period, duty_cycle, busy);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL t1_done_pulse done=%0b exp 0", done);
        end
    endtask

    task automatic test_rest_then_c3();
        int seen;
        clear_rom();
        rom[0] = ent(6'd0, 4'd0);
        rom[1] = ent(6'd1, 4'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        checks++;
        if (note_strobe !== 1'b1 || period !== 21'd0 || duty_cycle !== 21'd0) begin
            errors++;
            $display("FAIL t2_rest strobe=%0b period=%0d duty=%0d exp 1/0/0", note_strobe, period, duty_cycle);
        end
        for (int i = 1; i < 4; i++) begin
            tick();
            checks++;
            if (period !== 21'd0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL t2_rest_hold[%0d] period=%0d busy=%0b exp 0/1", i, period, busy);
            end
        end
        for (int i = 0; i < 7; i++) tick();
        checks++;
        if (note_strobe !== 1'b1 || period !== 21'd91734 || duty_cycle !== 21'd45867) begin
            errors++;
            $display("FAIL t2_c3 strobe=%0b period=%0d duty=%0d exp 1/91734/45867", note_strobe, period, duty_cycle);
        end
        seen = 0;
        for (int i = 0; i < 40 && seen == 0; i++) begin
            tick();
            if (done === 1'b1) seen = 1;
        end
        checks++;
        if (seen != 1) begin
            errors++;
            $display("FAIL t2_done_timeout seen=%0d exp 1", seen);
        end
    endtask

    task automatic test_high_and_unused();
        int seen;
        clear_rom();
        rom[0] = ent(6'd34, 4'd0);
        rom[1] = ent(6'd49, 4'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        checks++;
        if (note_strobe !== 1'b1 || period !== 21'd13636 || duty_cycle !== 21'd6818) begin
            errors++;
            $display("FAIL t2b_a5 strobe=%0b period=%0d duty=%0d exp 1/13636/6818", note_strobe, period, duty_cycle);
        end
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (note_strobe !== 1'b1 || period !== 21'd0 || duty_cycle !== 21'd0) begin
            errors++;
            $display("FAIL t2b_unused strobe=%0b period=%0d duty=%0d exp 1/0/0", note_strobe, period, duty_cycle);
        end
        seen = 0;
        for (int i = 0; i < 40 && seen == 0; i++) begin
            tick();
            if (done === 1'b1) seen = 1;
        end
        checks++;
        if (seen != 1) begin
            errors++;
            $display("FAIL t2b_done_timeout seen=%0d exp 1", seen);
        end
    endtask

    task automatic test_loop();
        int strobes, dones, fetch0, idle_cycles;
        clear_rom();
        rom[0] = ent(6'd22, 4'd1);
        loop_en = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        strobes = 0; dones = 0; fetch0 = 0; idle_cycles = 0;
        for (int i = 0; i < 48; i++) begin
            if (note_strobe === 1'b1) strobes++;
            if (done === 1'b1) dones++;
            if (rom_en === 1'b1 && rom_addr === 4'd0) fetch0++;
            if (busy !== 1'b1) idle_cycles++;
            tick();
        end
        checks++;
        if (strobes != 3 || fetch0 != 3) begin
            errors++;
            $display("FAIL t3_replays strobes=%0d fetch0=%0d exp 3/3", strobes, fetch0);
        end
        checks++;
        if (dones != 0 || idle_cycles != 0) begin
            errors++;
            $display("FAIL t3_no_done dones=%0d idle=%0d exp 0/0", dones, idle_cycles);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        loop_en = 1'b0;
        checks++;
        if (busy !== 1'b0 || period !== 21'd0) begin
            errors++;
            $display("FAIL t3_stop busy=%0b period=%0d exp 0/0", busy, period);
        end
    endtask

    task automatic test_stop();
        clear_rom();
        rom[0] = ent(6'd22, 4'd3);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        stop = 1'b1;
        start = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || period !== 21'd0 || duty_cycle !== 21'd0 || rom_en !== 1'b0) begin
            errors++;
            $display("FAIL t4_stop busy=%0b period=%0d duty=%0d en=%0b exp 0/0/0/0", busy, period, duty_cycle, rom_en);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || rom_en !== 1'b0) begin
            errors++;
            $display("FAIL t4_stop_over_start busy=%0b en=%0b exp 0/0", busy, rom_en);
        end
        stop = 1'b0;
        start = 1'b0;
        tick(); tick();
        checks++;
        if (busy !== 1'b0 || rom_en !== 1'b0 || note_strobe !== 1'b0) begin
            errors++;
            $display("FAIL t4_idle busy=%0b en=%0b strobe=%0b exp 0/0/0", busy, rom_en, note_strobe);
        end
    endtask

    task automatic test_addr_wrap();
        int strobes, fetch0, max_addr, cycles, seen;
        for (int i = 0; i < 16; i++) rom[i] = ent(6'd1, 4'd0);
        loop_en = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        strobes = 0; fetch0 = 0; max_addr = 0; cycles = 0; seen = 0;
        for (int i = 0; i < 400 && seen == 0; i++) begin
            if (done === 1'b1) begin
                seen = 1;
                cycles = i;
            end else begin
                if (note_strobe === 1'b1) strobes++;
                if (rom_en === 1'b1) begin
                    if (int'(rom_addr) > max_addr) max_addr = int'(rom_addr);
                    if (rom_addr === 4'd0) fetch0++;
                end
                tick();
            end
        end
        checks++;
        if (seen != 1 || cycles != 160) begin
            errors++;
            $display("FAIL t5_done seen=%0d cycle=%0d exp 1/160", seen, cycles);
        end
        checks++;
        if (strobes != 16 || max_addr != 15 || fetch0 != 1) begin
            errors++;
            $display("FAIL t5_walk strobes=%0d max_addr=%0d fetch0=%0d exp 16/15/1", strobes, max_addr, fetch0);
        end
        checks++;
        if (busy !== 1'b0 || period !== 21'd0) begin
            errors++;
            $display("FAIL t5_idle busy=%0b period=%0d exp 0/0", busy, period);
        end
    endtask

    task automatic test_reset_mid_gap();
        int bad;
        clear_rom();
        rom[0] = ent(6'd22, 4'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        for (int i = 0; i < 8; i++) tick();
        checks++;
        if (duty_cycle !== 21'd0 || period !== 21'd27273) begin
            errors++;
            $display("FAIL t6_in_gap duty=%0d period=%0d exp 0/27273", duty_cycle, period);
        end
        tick();
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({period, duty_cycle, rom_addr, rom_en, note_strobe, busy, done} !== '0) begin
            errors++;
            $display("FAIL t6_async_clear period=%0d duty=%0d addr=%0d en=%0b busy=%0b done=%0b exp all 0",
                     period, duty_cycle, rom_addr, rom_en, busy, done);
        end
        tick(); tick();
        reset = 1'b1;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (busy !== 1'b0 || rom_en !== 1'b0 || done !== 1'b0 || period !== 21'd0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL t6_idle_after_reset bad_cycles=%0d exp 0", bad);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || rom_en !== 1'b1 || rom_addr !== 4'd0) begin
            errors++;
            $display("FAIL t6_restart busy=%0b en=%0b addr=%0d exp 1/1/0", busy, rom_en, rom_addr);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_rom();
        test_reset();
        test_single_note();
        test_rest_then_c3();
        test_high_and_unused();
        test_loop();
        test_stop();
        test_addr_wrap();
        test_reset_mid_gap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
